// File: rtl/puf_race_controller.sv
// Sequences pairwise ring-oscillator races and assembles a challenge-masked PUF response.
// Each bit clears the counters, runs one race, then records the winner XOR the challenge bit.
module puf_race_controller #(
   parameter int RESP_BITS  = 8,
   parameter int SEL_W      = 3,
   parameter int CLR_CYCLES = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [RESP_BITS-1:0] challenge,
   input  logic                 fin_a,
   input  logic                 fin_b,
   output logic                 cnt_rst,
   output logic                 ro_en,
   output logic [SEL_W-1:0]     ro_sel,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_BITS-1:0] response,
   output logic                 tie_err,
   output logic                 tmo_err
);

   localparam int CNT_MAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT);
   localparam logic [SEL_W-1:0] BIT_LAST = SEL_W'(RESP_BITS - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, RACE, RECORD, FINISH} state_t;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     cyc_reg, cyc_next;
   logic [SEL_W-1:0]     bit_reg, bit_next;
   logic [RESP_BITS-1:0] chal_reg;
   logic [RESP_BITS-1:0] resp_reg, resp_next;
   logic                 tie_err_reg, tie_err_next;
   logic                 tmo_err_reg, tmo_err_next;
   logic                 win_reg, tie_reg, tmo_reg;
   logic                 rst_hold_reg;
   logic                 race_end;
   logic [RESP_BITS-1:0] bit_hit;

   // One-hot select of the response bit currently being recorded
   generate
      for (genvar gi = 0; gi < RESP_BITS; gi++) begin : g_hit
         assign bit_hit[gi] = (bit_reg == SEL_W'(gi));
      end
   endgenerate

   // A fin pulse on the TIMEOUT cycle still counts as a result, not a timeout
   assign race_end = fin_a | fin_b | (cyc_reg == TMO_LAST);

   always_comb begin
      state_next   = state_reg;
      cyc_next     = cyc_reg;
      bit_next     = bit_reg;
      resp_next    = resp_reg;
      tie_err_next = tie_err_reg;
      tmo_err_next = tmo_err_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = CLEAR;
               cyc_next     = '0;
               bit_next     = '0;
               resp_next    = '0;
               tie_err_next = 1'b0;
               tmo_err_next = 1'b0;
            end
         end
         CLEAR: begin
            if (cyc_reg == CLR_LAST) begin
               state_next = RACE;
               cyc_next   = '0;
            end else begin
               cyc_next = cyc_reg + 1'b1;
            end
         end
         RACE: begin
            if (race_end) begin
               state_next = RECORD;
            end else begin
               cyc_next = cyc_reg + 1'b1;
            end
         end
         RECORD: begin
            resp_next    = (resp_reg & ~bit_hit) | (bit_hit & ({RESP_BITS{win_reg}} ^ chal_reg));
            tie_err_next = tie_err_reg | tie_reg;
            tmo_err_next = tmo_err_reg | tmo_reg;
            cyc_next     = '0;
            if (bit_reg == BIT_LAST) begin
               state_next = FINISH;
            end else begin
               bit_next   = bit_reg + 1'b1;
               state_next = CLEAR;
            end
         end
         FINISH: begin
            state_next = IDLE;
            bit_next   = '0;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= IDLE;
         cyc_reg      <= '0;
         bit_reg      <= '0;
         chal_reg     <= '0;
         resp_reg     <= '0;
         tie_err_reg  <= 1'b0;
         tmo_err_reg  <= 1'b0;
         win_reg      <= 1'b0;
         tie_reg      <= 1'b0;
         tmo_reg      <= 1'b0;
         rst_hold_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cyc_reg      <= cyc_next;
         bit_reg      <= bit_next;
         resp_reg     <= resp_next;
         tie_err_reg  <= tie_err_next;
         tmo_err_reg  <= tmo_err_next;
         rst_hold_reg <= 1'b0;
         if (state_reg == IDLE && start) begin
            chal_reg <= challenge;
         end
         // Race outcome is latched at the exit edge and consumed in RECORD
         if (state_reg == RACE && race_end) begin
            win_reg <= fin_a & ~fin_b;
            tie_reg <= fin_a & fin_b;
            tmo_reg <= ~fin_a & ~fin_b;
         end
      end
   end

   // Counters are held cleared while in reset and for the edge that releases it
   assign cnt_rst  = rst_hold_reg | (state_reg == CLEAR);
   assign ro_en    = (state_reg == RACE);
   assign ro_sel   = (state_reg == CLEAR || state_reg == RACE || state_reg == RECORD) ? bit_reg : '0;
   assign busy     = (state_reg != IDLE);
   assign done     = (state_reg == FINISH);
   assign response = resp_reg;
   assign tie_err  = tie_err_reg;
   assign tmo_err  = tmo_err_reg;

endmodule

// File: tb/tb_puf_race_controller.sv
// Self-checking bench for puf_race_controller: table of race scenarios plus reset/abort sequence.
module tb_puf_race_controller;

   localparam int RESP_BITS  = 8;
   localparam int SEL_W      = 3;
   localparam int CLR_CYCLES = 2;
   localparam int TIMEOUT    = 255;

   logic                 clk;
   logic                 rst;
   logic                 start;
   logic [RESP_BITS-1:0] challenge;
   logic                 fin_a;
   logic                 fin_b;
   logic                 cnt_rst;
   logic                 ro_en;
   logic [SEL_W-1:0]     ro_sel;
   logic                 busy;
   logic                 done;
   logic [RESP_BITS-1:0] response;
   logic                 tie_err;
   logic                 tmo_err;

   puf_race_controller #(
      .RESP_BITS (RESP_BITS),
      .SEL_W     (SEL_W),
      .CLR_CYCLES(CLR_CYCLES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .challenge(challenge),
      .fin_a    (fin_a),
      .fin_b    (fin_b),
      .cnt_rst  (cnt_rst),
      .ro_en    (ro_en),
      .ro_sel   (ro_sel),
      .busy     (busy),
      .done     (done),
      .response (response),
      .tie_err  (tie_err),
      .tmo_err  (tmo_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-bit race mode: 0 fin_a wins, 1 fin_b wins, 2 tie, 3 no pulse (timeout)
   typedef struct {
      logic [7:0]  chal;
      logic [15:0] modes;
      int          delay;
      bit          noise;
      logic [7:0]  exp_resp;
      logic        exp_tie;
      logic        exp_tmo;
   } vec_t;

   typedef struct {
      logic [7:0] resp;
      logic       tie;
      logic       tmo;
   } exp_t;

   vec_t vecs[7];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   done_cnt = 0;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vector(input int idx, input vec_t v);
      int   n;
      int   r;
      int   d0;
      logic [1:0] mode;
      exp_t e;
      d0 = done_cnt;
      sb.push_back('{v.exp_resp, v.exp_tie, v.exp_tmo});
      challenge = v.chal;
      start = 1'b1;
      tick();
      start = 1'b0;
      challenge = ~v.chal;
      chk("busy_after_start", busy, 1);
      for (int b = 0; b < RESP_BITS; b++) begin
         mode = v.modes[2*b +: 2];
         chk("clear_cnt_rst", cnt_rst, 1);
         if (v.noise) begin
            fin_a = 1'b1;
            fin_b = 1'b1;
            start = 1'b1;
         end
         n = 0;
         while (!ro_en && n < 20) begin
            tick();
            fin_a = 1'b0;
            fin_b = 1'b0;
            start = 1'b0;
            n++;
         end
         chk("clear_len", n, CLR_CYCLES);
         chk("race_sel", ro_sel, b);
         chk("race_cnt_rst", cnt_rst, 0);
         if (mode != 2'd3) begin
            repeat (v.delay) tick();
            chk("race_still_on", ro_en, 1);
            fin_a = (mode == 2'd0 || mode == 2'd2);
            fin_b = (mode == 2'd1 || mode == 2'd2);
            tick();
            fin_a = 1'b0;
            fin_b = 1'b0;
            chk("race_exit", ro_en, 0);
         end else begin
            r = 0;
            while (ro_en && r < 400) begin
               tick();
               r++;
            end
            chk("timeout_len", r, TIMEOUT + 1);
         end
         chk("record_sel", ro_sel, b);
         chk("record_done_low", done, 0);
         tick();
      end
      chk("done_pulse", done, 1);
      chk("finish_sel", ro_sel, 0);
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("response", response, e.resp);
         chk("tie_err", tie_err, e.tie);
         chk("tmo_err", tmo_err, e.tmo);
      end
      tick();
      chk("done_single", done, 0);
      chk("idle_busy", busy, 0);
      chk("done_count", done_cnt - d0, 1);
      $display("vector %0d chal=%02h resp=%02h tie=%0b tmo=%0b", idx, v.chal, response, tie_err, tmo_err);
   endtask

   initial begin
      vecs[0] = '{8'h00, 16'h0000, 5,   1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 16'h0055, 5,   1'b0, 8'h55, 1'b0, 1'b0};
      vecs[2] = '{8'h00, 16'h0020, 5,   1'b0, 8'hFB, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 16'hC000, 5,   1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h3C, 16'h4444, 0,   1'b0, 8'h69, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 16'h0000, 255, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h0F, 16'h5555, 3,   1'b1, 8'h0F, 1'b0, 1'b0};

      rst = 1'b0;
      start = 1'b0;
      challenge = '0;
      fin_a = 1'b0;
      fin_b = 1'b0;
      tick();
      tick();
      chk("rst_cnt_rst", cnt_rst, 1);
      chk("rst_ro_en", ro_en, 0);
      chk("rst_ro_sel", ro_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_response", response, 0);
      chk("rst_errs", {tie_err, tmo_err}, 0);
      rst = 1'b1;
      tick();
      chk("post_rst_cnt_rst", cnt_rst, 0);

      for (int i = 0; i < 7; i++) begin
         run_vector(i, vecs[i]);
      end
      repeat (3) tick();
      chk("response_stable", response, vecs[6].exp_resp);

      // Abort a run during the race of bit 3; earlier bits time out so tmo_err is set before reset
      begin
         int n;
         int d0;
         d0 = done_cnt;
         challenge = 8'h00;
         start = 1'b1;
         tick();
         start = 1'b0;
         n = 0;
         while (!(ro_en && ro_sel == 3'd3) && n < 1500) begin
            tick();
            n++;
         end
         chk("reach_bit3", ro_sel, 3);
         chk("pre_rst_tmo", tmo_err, 1);
         rst = 1'b0;
         tick();
         rst = 1'b1;
         chk("abort_cnt_rst", cnt_rst, 1);
         chk("abort_ro_en", ro_en, 0);
         chk("abort_ro_sel", ro_sel, 0);
         chk("abort_busy", busy, 0);
         chk("abort_response", response, 0);
         chk("abort_errs", {tie_err, tmo_err}, 0);
         tick();
         chk("abort_cnt_rst_drop", cnt_rst, 0);
         repeat (4) tick();
         chk("abort_no_done", done_cnt - d0, 0);
         $display("abort sequence: busy=%0b response=%02h", busy, response);
      end
      run_vector(7, vecs[1]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
